// File: rtl/matrix_packet_writer.sv
`default_nettype none
// ============================================================================
// Module  : matrix_packet_writer (with design_variables package)
// Brief   : Writes one {stop, dir} packet per scored matrix cell into matrix
//           memory and tracks the maximum-score position for traceback.
// Revision: 1.0 - initial release
// ============================================================================

package design_variables;
    parameter int SEQ_LENGTH       = 32;
    parameter int SEQ_LENGTH_W     = 5;
    parameter int DATA_PACKET_SIZE = 3;
    parameter int SCORE_W          = 8;
    parameter logic [1:0] LEFT     = 2'b01;
    parameter logic [1:0] TOP      = 2'b10;
    parameter logic [1:0] DIAG     = 2'b11;
endpackage

module matrix_packet_writer #(
    parameter int SEQ_LENGTH       = design_variables::SEQ_LENGTH,
    parameter int SEQ_LENGTH_W     = design_variables::SEQ_LENGTH_W,
    parameter int DATA_PACKET_SIZE = design_variables::DATA_PACKET_SIZE,
    parameter int SCORE_W          = design_variables::SCORE_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_fill,
    input  logic                        cell_valid,
    output logic                        cell_ready,
    input  logic [SCORE_W-1:0]          cell_score,
    input  logic [1:0]                  cell_dir,
    output logic                        wr_en,
    output logic [SEQ_LENGTH_W-1:0]     wr_row,
    output logic [SEQ_LENGTH_W-1:0]     wr_col,
    output logic [DATA_PACKET_SIZE-1:0] wr_packet,
    output logic [SEQ_LENGTH_W-1:0]     max_row,
    output logic [SEQ_LENGTH_W-1:0]     max_col,
    output logic [SCORE_W-1:0]          max_score,
    output logic                        fill_done
);

    localparam logic [SEQ_LENGTH_W-1:0] c_last_idx = SEQ_LENGTH_W'(SEQ_LENGTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic                          w_accept;
    logic                          w_last;

    logic [SEQ_LENGTH_W-1:0]       r_row;
    logic [SEQ_LENGTH_W-1:0]       r_col;
    logic                          r_wr_en;
    logic [SEQ_LENGTH_W-1:0]       r_wr_row;
    logic [SEQ_LENGTH_W-1:0]       r_wr_col;
    logic [DATA_PACKET_SIZE-1:0]   r_wr_packet;
    logic [SEQ_LENGTH_W-1:0]       r_max_row;
    logic [SEQ_LENGTH_W-1:0]       r_max_col;
    logic [SCORE_W-1:0]            r_max_score;
    logic                          r_fill_done;

    // start_fill takes priority: a cell presented alongside it is dropped.
    always_comb begin
        w_state_next = r_state;
        w_last       = (r_row == c_last_idx) && (r_col == c_last_idx);
        w_accept     = cell_valid && (r_state == ST_FILL) && !start_fill;
        case (r_state)
            ST_IDLE: if (start_fill) w_state_next = ST_FILL;
            ST_FILL: begin
                if (start_fill)
                    w_state_next = ST_FILL;
                else if (w_accept && w_last)
                    w_state_next = ST_DONE;
            end
            ST_DONE: if (start_fill) w_state_next = ST_FILL;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_row    <= '0;
            r_wr_col    <= '0;
            r_wr_packet <= '0;
            r_max_row   <= '0;
            r_max_col   <= '0;
            r_max_score <= '0;
            r_fill_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wr_en     <= w_accept;
            r_fill_done <= w_accept && w_last;
            if (w_accept) begin
                r_wr_row    <= r_row;
                r_wr_col    <= r_col;
                r_wr_packet <= {(cell_score == '0), cell_dir};
            end
            if (start_fill) begin
                r_row       <= '0;
                r_col       <= '0;
                r_max_row   <= '0;
                r_max_col   <= '0;
                r_max_score <= '0;
            end else if (w_accept) begin
                // Row saturates at the last index; the FSM leaves FILL there.
                if (r_col == c_last_idx) begin
                    r_col <= '0;
                    if (r_row != c_last_idx)
                        r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                // Strict compare keeps the first position on ties.
                if (cell_score > r_max_score) begin
                    r_max_score <= cell_score;
                    r_max_row   <= r_row;
                    r_max_col   <= r_col;
                end
            end
        end
    end

    assign cell_ready = (r_state == ST_FILL);
    assign wr_en      = r_wr_en;
    assign wr_row     = r_wr_row;
    assign wr_col     = r_wr_col;
    assign wr_packet  = r_wr_packet;
    assign max_row    = r_max_row;
    assign max_col    = r_max_col;
    assign max_score  = r_max_score;
    assign fill_done  = r_fill_done;

endmodule

`default_nettype wire

// File: tb/tb_matrix_packet_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_matrix_packet_writer
// Brief   : Self-checking bench: table vectors plus scoreboard of expected writes.
// Revision: 1.0 - initial release
// ============================================================================
module tb_matrix_packet_writer;
    import design_variables::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_fill;
    logic       cell_valid;
    logic       cell_ready;
    logic [7:0] cell_score;
    logic [1:0] cell_dir;
    logic       wr_en;
    logic [4:0] wr_row;
    logic [4:0] wr_col;
    logic [2:0] wr_packet;
    logic [4:0] max_row;
    logic [4:0] max_col;
    logic [7:0] max_score;
    logic       fill_done;

    matrix_packet_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_fill (start_fill),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready),
        .cell_score (cell_score),
        .cell_dir   (cell_dir),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_packet  (wr_packet),
        .max_row    (max_row),
        .max_col    (max_col),
        .max_score  (max_score),
        .fill_done  (fill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] row;
        logic [4:0] col;
        logic [2:0] pkt;
        logic       done;
    } exp_t;

    typedef struct {
        logic [7:0] score;
        logic [1:0] dir;
        logic [2:0] pkt;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic       m_fill;
    logic [4:0] m_row, m_col, m_mrow, m_mcol;
    logic [7:0] m_max;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every write must match the oldest expected write.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (rst_n === 1'b1) begin
            if (wr_en === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got row=%0d col=%0d pkt=%b expected no write",
                             wr_row, wr_col, wr_packet);
                end else begin
                    e = sb.pop_front();
                    if ({wr_row, wr_col, wr_packet, fill_done} !== {e.row, e.col, e.pkt, e.done}) begin
                        errors++;
                        $display("FAIL write: got row=%0d col=%0d pkt=%b done=%b expected row=%0d col=%0d pkt=%b done=%b",
                                 wr_row, wr_col, wr_packet, fill_done, e.row, e.col, e.pkt, e.done);
                    end
                end
            end else if (fill_done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL fill_done_without_write: got %b expected 0", fill_done);
            end
        end
    end

    // One clock of stimulus; the bench model predicts acceptance and pushes expectations.
    task automatic cycle(input logic v, input logic [7:0] s, input logic [1:0] d, input logic sf,
                         input logic use_pkt = 1'b0, input logic [2:0] pkt = 3'b000);
        exp_t e;
        @(negedge clk);
        check("cell_ready", {31'b0, cell_ready}, {31'b0, m_fill});
        cell_valid = v;
        cell_score = s;
        cell_dir   = d;
        start_fill = sf;
        if (sf) begin
            m_row = 0; m_col = 0; m_max = 0; m_mrow = 0; m_mcol = 0; m_fill = 1'b1;
        end else if (v && m_fill) begin
            e.row  = m_row;
            e.col  = m_col;
            e.pkt  = use_pkt ? pkt : {(s == 8'd0), d};
            e.done = (m_row == 5'd31) && (m_col == 5'd31);
            sb.push_back(e);
            if (s > m_max) begin
                m_max = s; m_mrow = m_row; m_mcol = m_col;
            end
            if (e.done) m_fill = 1'b0;
            if (m_col == 5'd31) begin
                m_col = 0;
                if (m_row != 5'd31) m_row = m_row + 1'b1;
            end else begin
                m_col = m_col + 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 2'b00, 1'b0);
    endtask

    task automatic check_max(input string name, input logic [4:0] r, input logic [4:0] c, input logic [7:0] s);
        check({name, "_row"}, {27'b0, max_row}, {27'b0, r});
        check({name, "_col"}, {27'b0, max_col}, {27'b0, c});
        check({name, "_score"}, {24'b0, max_score}, {24'b0, s});
    endtask

    task automatic check_drained(input string name);
        check(name, sb.size(), 0);
    endtask

    vec_t tbl[6];
    int   idx;
    logic v;

    initial begin
        tbl[0] = '{score: 8'd0,   dir: LEFT,  pkt: {1'b1, LEFT}};
        tbl[1] = '{score: 8'd5,   dir: TOP,   pkt: {1'b0, TOP}};
        tbl[2] = '{score: 8'd255, dir: DIAG,  pkt: {1'b0, DIAG}};
        tbl[3] = '{score: 8'd0,   dir: DIAG,  pkt: {1'b1, DIAG}};
        tbl[4] = '{score: 8'd1,   dir: 2'b00, pkt: 3'b000};
        tbl[5] = '{score: 8'd0,   dir: TOP,   pkt: {1'b1, TOP}};

        rst_n = 1'b0; start_fill = 1'b0; cell_valid = 1'b0; cell_score = '0; cell_dir = '0;
        m_fill = 1'b0; m_row = 0; m_col = 0; m_max = 0; m_mrow = 0; m_mcol = 0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", {31'b0, wr_en}, 0);
        check("rst_wr_row", {27'b0, wr_row}, 0);
        check("rst_wr_col", {27'b0, wr_col}, 0);
        check("rst_wr_packet", {29'b0, wr_packet}, 0);
        check("rst_fill_done", {31'b0, fill_done}, 0);
        check("rst_cell_ready", {31'b0, cell_ready}, 0);
        check_max("rst_max", 5'd0, 5'd0, 8'd0);
        rst_n = 1'b1;
        idle(2);

        // Full matrix, score = index % 200.
        cycle(1'b0, 8'd0, 2'b00, 1'b1);
        for (int i = 0; i < 1024; i++) cycle(1'b1, 8'(i % 200), 2'(i % 4), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'd250, LEFT, 1'b0);
        idle(2);
        check_max("full_max", 5'd6, 5'd7, 8'd199);
        check_max("full_model", m_mrow, m_mcol, m_max);
        check_drained("full_drained");

        // Packet encoding vectors.
        cycle(1'b0, 8'd0, 2'b00, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, tbl[i].score, tbl[i].dir, 1'b0, 1'b1, tbl[i].pkt);
        idle(2);
        check_drained("table_drained");

        // Tied maxima with random valid gaps across row wraps.
        cycle(1'b0, 8'd0, 2'b00, 1'b1);
        idx = 0;
        while (idx < 300) begin
            v = 1'($urandom_range(0, 1));
            cycle(v, (idx == 100 || idx == 289) ? 8'd50 : 8'(idx % 40), 2'(idx % 4), 1'b0);
            if (v) idx++;
        end
        idle(2);
        check_max("tie_max", 5'd3, 5'd4, 8'd50);
        check_drained("tie_drained");

        // Restart mid-fill at cell 500, colliding with a valid cell.
        while (idx < 500) begin
            cycle(1'b1, 8'(idx % 40), 2'(idx % 4), 1'b0);
            idx++;
        end
        cycle(1'b1, 8'd99, DIAG, 1'b1);
        cycle(1'b0, 8'd0, 2'b00, 1'b0);
        check_max("restart_clear", 5'd0, 5'd0, 8'd0);
        cycle(1'b1, 8'd0, TOP, 1'b0);
        cycle(1'b1, 8'd9, LEFT, 1'b0);
        idle(2);
        check_max("restart_max", 5'd0, 5'd1, 8'd9);
        check_drained("restart_drained");

        // Reset right after an accept: the in-flight write must vanish.
        @(negedge clk);
        cell_valid = 1'b1; cell_score = 8'd77; cell_dir = DIAG; start_fill = 1'b0;
        @(posedge clk);
        rst_n = 1'b0;
        cell_valid = 1'b0;
        m_fill = 1'b0;
        #1;
        check("rst_mid_wr_en", {31'b0, wr_en}, 0);
        check("rst_mid_fill_done", {31'b0, fill_done}, 0);
        check("rst_mid_wr_row", {27'b0, wr_row}, 0);
        check("rst_mid_wr_col", {27'b0, wr_col}, 0);
        check("rst_mid_wr_packet", {29'b0, wr_packet}, 0);
        check("rst_mid_cell_ready", {31'b0, cell_ready}, 0);
        check_max("rst_mid_max", 5'd0, 5'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'd5, TOP, 1'b0);
        cycle(1'b0, 8'd0, 2'b00, 1'b1);
        cycle(1'b1, 8'd5, TOP, 1'b0);
        idle(2);
        check_max("post_rst_max", 5'd0, 5'd0, 8'd5);
        check_drained("post_rst_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
